// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
// Module   : console_pkg
// Brief    : Register map, STATUS bit positions and shifter states for the
//            console UART transmitter.
// Revision : 1.0
// ============================================================================
package console_pkg;

    localparam logic [7:0] CON_TXDATA = 8'h00;
    localparam logic [7:0] CON_STATUS = 8'h04;
    localparam logic [7:0] CON_LEVEL  = 8'h08;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage : console_pkg
`default_nettype wire

// File: rtl/console_fifo.sv
`default_nettype none
// ============================================================================
// Module   : console_fifo
// Brief    : Synchronous show-ahead FIFO; pointers carry one extra wrap bit.
// Revision : 1.0
// ============================================================================
module console_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] c_DEPTH   = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign level     = r_wr_ptr - r_rd_ptr;
    assign full      = (level == c_DEPTH);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];
    // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule : console_fifo
`default_nettype wire

// File: rtl/console_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : console_uart_tx
// Brief    : MIO console peripheral: register decode, TX FIFO and 8N1 shifter.
// Revision : 1.0
// ============================================================================
module console_uart_tx
    import console_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        console_we,
    input  logic [11:0] console_addr,
    input  logic [31:0] Peripheral_in,
    output logic [7:0]  console_out,
    output logic        txd,
    output logic        tx_irq
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] c_DIV_ONE  = DIV_W'(1);
    localparam logic [LVL_W-1:0] c_LVL_ONE  = LVL_W'(1);

    tx_state_t        r_state, w_state_next;
    logic [DIV_W-1:0] r_div, w_div_next;
    logic [2:0]       r_bit, w_bit_next;
    logic [7:0]       r_shift, w_shift_next;
    logic             r_txd, w_txd_next;
    logic             r_irq, r_ovf;

    logic             w_wr_data, w_wr_status;
    logic             w_push, w_pop, w_full, w_empty, w_empty_next, w_wrap;
    logic [7:0]       w_head;
    logic [LVL_W-1:0] w_level;
    logic             w_unused;

    assign w_unused    = ^{console_addr[11:8], Peripheral_in[31:8]};
    assign w_wr_data   = console_we && (console_addr[7:0] == CON_TXDATA);
    assign w_wr_status = console_we && (console_addr[7:0] == CON_STATUS);
    assign w_push      = w_wr_data && !w_full;
    assign w_wrap      = (r_div == c_DIV_LAST);
    // Lets tx_irq track the FIFO from the flop that follows this edge.
    assign w_empty_next = (w_empty && !w_push) ||
                          ((w_level == c_LVL_ONE) && w_pop && !w_push);

    console_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (Peripheral_in[7:0]),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_wr_data && w_full) begin
            r_ovf <= 1'b1;
        end else if (w_wr_status && Peripheral_in[ST_OVF]) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_irq   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_txd   <= w_txd_next;
            r_irq   <= w_empty_next && (w_state_next == TX_IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div + c_DIV_ONE;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            TX_IDLE: begin
                w_div_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = TX_START;
                end
            end
            TX_START: begin
                if (w_wrap) begin
                    w_div_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_wrap) begin
                    w_div_next   = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_wrap) begin
                    w_div_next   = '0;
                    w_state_next = TX_IDLE;
                end
            end
            default: w_state_next = TX_IDLE;
        endcase

        // The pin flop is loaded with the level of the state being entered.
        case (w_state_next)
            TX_START: w_txd_next = 1'b0;
            TX_DATA:  w_txd_next = w_shift_next[0];
            default:  w_txd_next = 1'b1;
        endcase
    end

    always_comb begin
        console_out = 8'h00;
        case (console_addr[7:0])
            CON_STATUS: begin
                console_out[ST_FULL]  = w_full;
                console_out[ST_EMPTY] = w_empty;
                console_out[ST_BUSY]  = (r_state != TX_IDLE);
                console_out[ST_OVF]   = r_ovf;
            end
            CON_LEVEL: console_out = 8'(w_level);
            default:   console_out = 8'h00;
        endcase
    end

    assign txd    = r_txd;
    assign tx_irq = r_irq;

endmodule : console_uart_tx
`default_nettype wire

// File: tb/tb_console_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_console_uart_tx
// Brief    : Scoreboard bench: accepted bytes are queued, a line receiver
//            decodes 8N1 frames from txd and compares them in order.
// Revision : 1.0
// ============================================================================
module tb_console_uart_tx;
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        console_we;
    logic [11:0] console_addr;
    logic [31:0] Peripheral_in;
    logic [7:0]  console_out;
    logic        txd;
    logic        tx_irq;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [7:0]  exp_q[$];
    int          start_times[$];

    console_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .console_we    (console_we),
        .console_addr  (console_addr),
        .Peripheral_in (Peripheral_in),
        .console_out   (console_out),
        .txd           (txd),
        .tx_irq        (tx_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [11:0] a, input logic [7:0] exp, input string name);
        console_addr = a;
        #1;
        check(name, {24'd0, console_out}, {24'd0, exp});
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        console_we    = 1'b1;
        console_addr  = a;
        Peripheral_in = {24'($urandom), d};
        @(negedge clk);
        console_we    = 1'b0;
    endtask

    task automatic send(input logic [11:0] a, input logic [7:0] d);
        exp_q.push_back(d);
        wr(a, d);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (tx_irq !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, {31'd0, tx_irq}, 32'd1);
    endtask

    // Line receiver: samples the middle of each bit period after a falling edge.
    initial begin : monitor
        bit         active = 1'b0;
        int         cnt    = 0;
        logic [7:0] b      = '0;
        logic       prev   = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                active = 1'b0;
                prev   = 1'b1;
            end else begin
                if (!active) begin
                    if (prev && !txd) begin
                        active = 1'b1;
                        cnt    = 0;
                        start_times.push_back(cyc);
                    end
                end else begin
                    cnt++;
                    if (cnt == CLK_DIV / 2) check("start_bit", {31'd0, txd}, 32'd0);
                    for (int i = 0; i < 8; i++)
                        if (cnt == CLK_DIV * (i + 1) + CLK_DIV / 2) b[i] = txd;
                    if (cnt == 9 * CLK_DIV + CLK_DIV / 2) begin
                        check("stop_bit", {31'd0, txd}, 32'd1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame_byte: got 0x%0h, expected no frame", b);
                        end else begin
                            check("frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                        end
                        active = 1'b0;
                    end
                end
                prev = txd;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        int         sz;
        int         n;
        logic [7:0] b;
        rst           = 1'b1;
        console_we    = 1'b0;
        console_addr  = '0;
        Peripheral_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        rd(12'h004, 8'h02, "reset_status");
        rd(12'h008, 8'h00, "reset_level");
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_irq", {31'd0, tx_irq}, 32'd1);

        // Single byte 0xA5 with cycle-exact line checks
        send(12'h000, 8'hA5);
        check("a5_irq_fall", {31'd0, tx_irq}, 32'd0);
        check("a5_txd_n1", {31'd0, txd}, 32'd1);
        @(negedge clk);
        check("a5_txd_n2", {31'd0, txd}, 32'd0);
        rd(12'h004, 8'h06, "a5_status_busy");
        repeat (3) @(negedge clk);
        check("a5_txd_n5", {31'd0, txd}, 32'd0);
        @(negedge clk);
        check("a5_bit0", {31'd0, txd}, 32'd1);
        repeat (35) @(negedge clk);
        check("a5_stop_txd", {31'd0, txd}, 32'd1);
        check("a5_irq_in_stop", {31'd0, tx_irq}, 32'd0);
        @(negedge clk);
        check("a5_irq_rise", {31'd0, tx_irq}, 32'd1);

        // Back-to-back frames: start-to-start period
        sz = start_times.size();
        send(12'h000, 8'h00);
        send(12'h000, 8'hFF);
        wait_idle("b2b");
        check("b2b_frames", start_times.size(), sz + 2);
        if (start_times.size() == sz + 2)
            check("b2b_gap", start_times[sz + 1] - start_times[sz], 10 * CLK_DIV + 1);

        // Fill to full, overflow, clear
        for (int i = 0; i < 17; i++) send(12'h000, 8'($urandom));
        rd(12'h008, 8'h10, "fill_level");
        rd(12'h004, 8'h05, "fill_status");
        wr(12'h000, 8'hEE);
        rd(12'h004, 8'h0D, "ovf_status");
        rd(12'h008, 8'h10, "ovf_level");
        wr(12'h004, 8'h08);
        rd(12'h004, 8'h05, "ovf_cleared");
        wait_idle("fill");

        // Unmapped and read-only offsets
        rd(12'h00C, 8'h00, "rd_0c");
        rd(12'h080, 8'h00, "rd_80");
        rd(12'h000, 8'h00, "rd_txdata");
        wr(12'h010, 8'hFF);
        wr(12'h008, 8'hFF);
        rd(12'h004, 8'h02, "unmapped_status");
        rd(12'h008, 8'h00, "unmapped_level");
        repeat (3) @(negedge clk);
        check("unmapped_txd", {31'd0, txd}, 32'd1);
        check("unmapped_irq", {31'd0, tx_irq}, 32'd1);

        // Upper address bits are not decoded
        send(12'hF00, 8'h3C);
        wait_idle("hiaddr");

        // Reset during data bit 3 discards the frame and the queue
        wr(12'h000, 8'h81);
        wr(12'h000, 8'h42);
        wr(12'h000, 8'h24);
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_txd", {31'd0, txd}, 32'd1);
        check("midrst_irq", {31'd0, tx_irq}, 32'd1);
        rd(12'h008, 8'h00, "midrst_level");
        rd(12'h004, 8'h02, "midrst_status");
        send(12'h000, 8'h55);
        wait_idle("post_rst");

        // Random bursts from idle; level after the burst follows the one-pop rule
        for (int k = 0; k < 5; k++) begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                send({4'($urandom), 8'h00}, b);
            end
            rd(12'h008, 8'((n == 1) ? 1 : n - 1), "rand_level");
            wait_idle("rand");
        end

        repeat (2 * CLK_DIV) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_console_uart_tx
`default_nettype wire

// File: doc/console_uart_tx.md
# console_uart_tx

Memory-mapped console peripheral answering the `0xD` address window of the MIO bus. CPU stores to the TX data register enqueue bytes into a 16-entry FIFO, and a UART shifter drains them as 8N1 frames on `txd`. Status and level registers are readable through `console_out`, so software can poll before writing.

## Interface
- `CLK_DIV`, default 868: clock cycles per bit (100 MHz / 115200). Legal values are ≥2.
- `FIFO_DEPTH`, default 16: TX FIFO entries. Must be a power of 2, ≥2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `console_we`  in  1  write strobe from the bus. One register write per cycle in which it is high.
- `console_addr`  in  12  byte address within the window. Only `[7:0]` is decoded; `[11:8]` is ignored.
- `Peripheral_in`  in  32  write data. Only `[7:0]` is used.
- `console_out`  out  8  read data. Combinational from `console_addr` and current state.
- `txd`  out  1  serial output. Idle high.
- `tx_irq`  out  1  registered; high while the FIFO is empty and the shifter is idle.

## Operation
- Register map (`console_addr[7:0]`):
  - `0x00` TXDATA.
    - Write: push `Peripheral_in[7:0]`.
    - Read: 0.
  - `0x04` STATUS.
    - Read: bit0 full, bit1 empty, bit2 busy (shifter not IDLE), bit3 overflow (sticky), bits[7:4] = 0.
    - Write with bit3 = 1: clears overflow. Other bits are ignored.
  - `0x08` LEVEL.
    - Read: FIFO occupancy, zero-extended to 8 bits.
    - Write: ignored.
  - Any other offset: reads 0, writes ignored.
- Reads have no side effects.
- Push rules:
  - A push while full is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
  - Push and pop in the same cycle while not full: level is unchanged and both succeed.
  - Overflow set and clear in the same cycle: set wins.
- Shifter FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `txd` = 1. If the FIFO is not empty, pop the head into the shift register and go to START.
  - START: `txd` = 0 for `CLK_DIV` cycles.
  - DATA: 8 bits, LSB first, each held `CLK_DIV` cycles. The 3-bit bit counter advances when the divider wraps.
  - STOP: `txd` = 1 for `CLK_DIV` cycles, then IDLE.
- The divider counter is `$clog2(CLK_DIV)` bits wide. It reloads to 0 on every state entry and wraps at `CLK_DIV-1`.
- `txd` is driven from a flop; no combinational path to the pin.
- Reset values:
  - `txd` = 1, `tx_irq` = 1.
  - FIFO empty, level 0, overflow 0.
  - FSM in IDLE, divider 0, bit counter 0.

## Timing
- Write in cycle N to an empty FIFO with the shifter idle:
  - FIFO is non-empty in N+1; the FSM pops and enters START at the end of N+1.
  - `txd` falls in cycle N+2.
  - `tx_irq` falls in N+1.
- Frame length is `10*CLK_DIV` cycles, plus exactly 1 IDLE cycle before the next frame. Frame period for back-to-back bytes is therefore `10*CLK_DIV+1`.
- STATUS, LEVEL and `tx_irq` reflect flop state, so a write is visible one cycle later.
- `console_out` settles in the same cycle as `console_addr` (single-cycle bus read).
- Reset mid-frame: `txd` is 1 from the cycle after `rst`, and FIFO contents are discarded. A truncated frame on the line is acceptable.
- `console_we` held for k cycles is k writes. The bus issues one-cycle strobes.

## Structure
- Package `console_pkg` holds:
  - register offsets: `CON_TXDATA` = 8'h00, `CON_STATUS` = 8'h04, `CON_LEVEL` = 8'h08;
  - STATUS bit indices: `ST_FULL` = 0, `ST_EMPTY` = 1, `ST_BUSY` = 2, `ST_OVF` = 3;
  - FSM state enum `tx_state_t`.
- Sub-module `console_fifo`: synchronous FIFO, parameters width 8 and depth `FIFO_DEPTH`.
  - Ports: push, pop, din, dout (head, show-ahead), full, empty, level.
  - Pointers are one bit wider than the address to distinguish full from empty.
  - Pointers wrap modulo `2*FIFO_DEPTH`.
- Top level contains the register decode, overflow flag, FSM, divider and shifter.

## Test plan
All scenarios use `CLK_DIV` = 4 and `FIFO_DEPTH` = 16.
- Reset, then read `0x04` → `0x02`. Read `0x08` → `0x00`. `txd` = 1, `tx_irq` = 1.
- Write `0x00` ← `0xA5` in cycle N:
  - `txd` low over N+2..N+5;
  - data bits 1,0,1,0,0,1,0,1 at 4 cycles each;
  - stop bit high;
  - `tx_irq` rises after the STOP state completes.
- 17 writes in consecutive cycles while idle:
  - the first byte is popped, so the FIFO ends at level 16 (`0x08` reads `0x10`);
  - the 18th write is dropped and STATUS reads `0x0D` (full | busy | overflow).
  - Write `0x04` ← `0x08`; STATUS then reads `0x05`.
- Back-to-back bytes `0x00`, `0xFF`: second start bit begins exactly 41 cycles after the first start bit.
- Assert `rst` during the DATA bit 3 state:
  - next cycle `txd` = 1 and LEVEL = 0;
  - a following write of `0x55` transmits a clean frame.
- Read `0x0C` and `0x80` → 0. Write `0x10` ← `0xFF` → no state change.
